// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - pipelined WIDTH x WIDTH unsigned multiplier with per-transaction approximate mode
// Low APPROX_COLS columns are carry-free ORs in approx mode; three stages, valid/ready, global stall enable.
module approx_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 out_approx,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;

  logic             r_s1_valid, r_s2_valid, r_s3_valid;
  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic             r_s1_approx, r_s2_approx, r_s3_approx;
  logic [PW-1:0]    r_s2_sum, r_s2_carry, r_s2_low;
  logic [PW-1:0]    r_s3_p;

  logic             w_en;
  logic [PW-1:0]    w_lo_mask, w_row, w_maj, w_sum, w_carry, w_low;

  assign w_en       = ~(r_s3_valid & ~out_ready);
  assign in_ready   = w_en;
  assign out_valid  = r_s3_valid;
  assign out_p      = r_s3_p;
  assign out_approx = r_s3_approx;
  assign busy       = r_s1_valid | r_s2_valid | r_s3_valid;

  // Each shifted row feeds its low-column bits into the OR vector and the rest into a 3:2 CSA chain.
  always_comb begin
    w_lo_mask = '0;
    w_row     = '0;
    w_maj     = '0;
    w_sum     = '0;
    w_carry   = '0;
    w_low     = '0;
    for (int m = 0; m < PW; m++) begin
      w_lo_mask[m] = r_s1_approx && (m < APPROX_COLS);
    end
    for (int j = 0; j < WIDTH; j++) begin
      w_row   = PW'(r_s1_a & {WIDTH{r_s1_b[j]}}) << j;
      w_low   = w_low | (w_row & w_lo_mask);
      w_row   = w_row & ~w_lo_mask;
      w_maj   = (w_sum & w_carry) | (w_sum & w_row) | (w_carry & w_row);
      w_sum   = w_sum ^ w_carry ^ w_row;
      w_carry = w_maj << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_approx <= 1'b0;
      r_s2_approx <= 1'b0;
      r_s3_approx <= 1'b0;
      r_s2_sum    <= '0;
      r_s2_carry  <= '0;
      r_s2_low    <= '0;
      r_s3_p      <= '0;
    end else if (w_en) begin
      r_s1_valid  <= in_valid;
      r_s1_a      <= in_a;
      r_s1_b      <= in_b;
      r_s1_approx <= in_approx;
      r_s2_valid  <= r_s1_valid;
      r_s2_approx <= r_s1_approx;
      r_s2_sum    <= w_sum;
      r_s2_carry  <= w_carry;
      r_s2_low    <= w_low;
      r_s3_valid  <= r_s2_valid;
      r_s3_approx <= r_s2_approx;
      // High part has no bits below APPROX_COLS, so OR merges the low columns without overlap.
      r_s3_p      <= (r_s2_sum + r_s2_carry) | r_s2_low;
    end
  end

endmodule
